// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, write-allocate data cache.
// It sits between the single-word CPU data port and the line-based memory
// data port. Every write is sent to memory as a full-line write, so the cache
// never holds dirty data.
//
// Ports:
//   clk, reset_n                 rising-edge clock, asynchronous active-low reset
//   c_readC / c_writeC           CPU request (held until c_doneC); both high = write
//   c_address, c_wdata           CPU word address and write data
//   c_rdata, c_doneC             read data and one-cycle completion pulse
//   m_readM / m_writeM           line read / line write request to memory
//   m_address                    line-aligned address {tag, index, 2'b00}
//   m_data                       64-bit line bus; driven only while m_writeM=1
//   m_readyM, m_input_readyM,    memory idle / read line valid / op complete
//   m_doneM
//   hit_count, miss_count        saturating performance counters
module dcache_wt #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            c_readC,
  input  logic                            c_writeC,
  input  logic [WORD_SIZE-1:0]            c_address,
  input  logic [WORD_SIZE-1:0]            c_wdata,
  output logic [WORD_SIZE-1:0]            c_rdata,
  output logic                            c_doneC,
  output logic                            m_readM,
  output logic                            m_writeM,
  output logic [WORD_SIZE-1:0]            m_address,
  inout  wire  [WORD_SIZE*LINE_WORDS-1:0] m_data,
  input  logic                            m_readyM,
  input  logic                            m_input_readyM,
  input  logic                            m_doneM,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
);

  localparam int LINES     = 1 << INDEX_BITS;
  localparam int OFF_BITS  = $clog2(LINE_WORDS);
  localparam int TAG_BITS  = WORD_SIZE - OFF_BITS - INDEX_BITS;
  localparam int LINE_BITS = WORD_SIZE * LINE_WORDS;

  typedef enum logic [2:0] {
    IDLE, FILL_REQ, FILL_WAIT, WB_REQ, WB_WAIT, RESP
  } state_e;

  state_e                    state_q;
  logic [WORD_SIZE-1:0]      addr_q;
  logic [WORD_SIZE-1:0]      wdata_q;
  logic                      is_write_q;
  logic [WORD_SIZE-1:0]      rdata_q;
  logic [15:0]               hit_q;
  logic [15:0]               miss_q;
  logic [LINES-1:0]          valid_q;
  logic [TAG_BITS-1:0]       tag_q  [LINES];
  logic [LINE_BITS-1:0]      data_q [LINES];

  // Address split for the live CPU request (used in IDLE) and the latched one.
  logic [OFF_BITS-1:0]       req_off,  addr_off;
  logic [INDEX_BITS-1:0]     req_idx,  addr_idx;
  logic [TAG_BITS-1:0]       req_tag,  addr_tag;
  logic                      req_hit;

  assign req_off  = c_address[OFF_BITS-1:0];
  assign req_idx  = c_address[OFF_BITS +: INDEX_BITS];
  assign req_tag  = c_address[WORD_SIZE-1 -: TAG_BITS];
  assign addr_off = addr_q[OFF_BITS-1:0];
  assign addr_idx = addr_q[OFF_BITS +: INDEX_BITS];
  assign addr_tag = addr_q[WORD_SIZE-1 -: TAG_BITS];
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  function automatic logic [LINE_BITS-1:0] merge_word(
    input logic [LINE_BITS-1:0] line,
    input logic [OFF_BITS-1:0]  off,
    input logic [WORD_SIZE-1:0] word
  );
    logic [LINE_BITS-1:0] merged;
    merged = line;
    merged[int'(off)*WORD_SIZE +: WORD_SIZE] = word;
    return merged;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Memory-side request signals are decoded straight from the state so a
  // request drops in the cycle right after the memory accepts it.
  assign m_readM   = (state_q == FILL_REQ);
  assign m_writeM  = (state_q == WB_REQ);
  assign m_address = {addr_q[WORD_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign m_data    = m_writeM ? data_q[addr_idx] : {LINE_BITS{1'bz}};

  assign c_doneC    = (state_q == RESP);
  assign c_rdata    = rdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  // Line/tag array write port: a write hit merges in IDLE, a fill (optionally
  // merged with the pending write word) lands in FILL_WAIT.
  logic                   line_we;
  logic                   tag_we;
  logic [INDEX_BITS-1:0]  line_idx;
  logic [LINE_BITS-1:0]   line_wdata;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    line_we    = 1'b0;
    tag_we     = 1'b0;
    line_idx   = addr_idx;
    line_wdata = data_q[addr_idx];
    if (state_q == IDLE && c_writeC && req_hit) begin
      line_we    = 1'b1;
      line_idx   = req_idx;
      line_wdata = merge_word(data_q[req_idx], req_off, c_wdata);
    end else if (state_q == FILL_WAIT && m_input_readyM) begin
      line_we    = 1'b1;
      tag_we     = 1'b1;
      line_wdata = is_write_q ? merge_word(m_data, addr_off, wdata_q) : m_data;
    end
  end

  // NOTE: tag/data arrays have no reset; the cleared valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[line_idx] <= line_wdata;
      if (tag_we) tag_q[line_idx] <= addr_tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (c_readC || c_writeC) begin
            addr_q     <= c_address;
            wdata_q    <= c_wdata;
            is_write_q <= c_writeC;
            if (req_hit) begin
              hit_q <= sat_inc(hit_q);
              if (c_writeC) begin
                state_q <= WB_REQ;
              end else begin
                rdata_q <= data_q[req_idx][int'(req_off)*WORD_SIZE +: WORD_SIZE];
                state_q <= RESP;
              end
            end else begin
              miss_q  <= sat_inc(miss_q);
              state_q <= FILL_REQ;
            end
          end
        end
        FILL_REQ:  if (m_readyM) state_q <= FILL_WAIT;
        FILL_WAIT: begin
          if (m_input_readyM) begin
            valid_q[addr_idx] <= 1'b1;
            if (is_write_q) begin
              state_q <= WB_REQ;
            end else begin
              rdata_q <= m_data[int'(addr_off)*WORD_SIZE +: WORD_SIZE];
              state_q <= RESP;
            end
          end
        end
        WB_REQ:    if (m_readyM) state_q <= WB_WAIT;
        WB_WAIT:   if (m_doneM)  state_q <= RESP;
        RESP:      state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt with a small line-based memory model
// (LATENCY=6: line data / done is sampled five edges after acceptance).
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        c_readC = 1'b0;
  logic        c_writeC = 1'b0;
  logic [15:0] c_address = '0;
  logic [15:0] c_wdata = '0;
  logic [15:0] c_rdata;
  logic        c_doneC;
  logic        m_readM;
  logic        m_writeM;
  logic [15:0] m_address;
  wire  [63:0] m_data;
  logic        m_readyM;
  logic        m_input_readyM;
  logic        m_doneM;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dcache_wt dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .c_readC        (c_readC),
    .c_writeC       (c_writeC),
    .c_address      (c_address),
    .c_wdata        (c_wdata),
    .c_rdata        (c_rdata),
    .c_doneC        (c_doneC),
    .m_readM        (m_readM),
    .m_writeM       (m_writeM),
    .m_address      (m_address),
    .m_data         (m_data),
    .m_readyM       (m_readyM),
    .m_input_readyM (m_input_readyM),
    .m_doneM        (m_doneM),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  // ---------------- memory model (synchronous reset) ----------------
  logic [15:0] mem [1024];
  logic        ready_q;
  logic        hold_ready = 1'b0;
  int          busy_cnt;
  logic        busy_rd;
  logic [9:0]  busy_addr;
  logic [63:0] mem_rline;

  assign m_readyM = ready_q & ~hold_ready;
  assign m_data   = m_input_readyM ? mem_rline : 64'hz;

  always @(posedge clk) begin
    if (!reset_n) begin
      ready_q        <= 1'b1;
      m_input_readyM <= 1'b0;
      m_doneM        <= 1'b0;
      busy_cnt       <= 0;
      busy_rd        <= 1'b0;
      busy_addr      <= '0;
      mem_rline      <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
      mem[10'h024] <= 16'hF01C;
      mem[10'h025] <= 16'h6100;
      mem[10'h026] <= 16'hAAAA;
      mem[10'h027] <= 16'h6200;
      mem[10'h034] <= 16'hF41C;
      mem[10'h022] <= 16'h5A5A;
    end else begin
      m_input_readyM <= 1'b0;
      m_doneM        <= 1'b0;
      if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          ready_q <= 1'b1;
          if (busy_rd) begin
            m_input_readyM <= 1'b1;
            mem_rline <= {mem[busy_addr + 10'd3], mem[busy_addr + 10'd2],
                          mem[busy_addr + 10'd1], mem[busy_addr]};
          end else begin
            m_doneM <= 1'b1;
          end
        end
      end else if (m_readyM && (m_readM || m_writeM)) begin
        ready_q   <= 1'b0;
        busy_cnt  <= 4;
        busy_rd   <= m_readM;
        busy_addr <= m_address[9:0];
        if (m_writeM) begin
          mem[m_address[9:0]]         <= m_data[15:0];
          mem[m_address[9:0] + 10'd1] <= m_data[31:16];
          mem[m_address[9:0] + 10'd2] <= m_data[47:32];
          mem[m_address[9:0] + 10'd3] <= m_data[63:48];
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one CPU request and waits (bounded) for c_doneC. lat is the number
  // of edges after E0 before done (-1 on timeout).
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input int stall,
                        output int lat, output logic [15:0] rdata,
                        output int rd_cyc, output int wr_cyc,
                        output logic [15:0] maddr, output logic [63:0] mdata);
    lat = -1; rdata = '0; rd_cyc = 0; wr_cyc = 0; maddr = '0; mdata = '0;
    @(negedge clk);
    c_readC = rd; c_writeC = wr; c_address = addr; c_wdata = wd;
    hold_ready = (stall > 0);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (m_readM)  begin rd_cyc++; maddr = m_address; end
      if (m_writeM) begin wr_cyc++; maddr = m_address; mdata = m_data; end
      if (k == stall + 1) hold_ready = 1'b0;
      if (c_doneC) begin lat = k - 1; rdata = c_rdata; break; end
    end
    hold_ready = 1'b0;
    @(negedge clk);
    c_readC = 1'b0; c_writeC = 1'b0;
  endtask

  int          lat, rdc, wrc;
  logic [15:0] rdata, maddr;
  logic [63:0] mdata;

  initial begin
    // Reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_done",   c_doneC,    1'b0);
    check("rst_readM",  m_readM,    1'b0);
    check("rst_writeM", m_writeM,   1'b0);
    check("rst_rdata",  c_rdata,    16'h0000);
    check("rst_hits",   hit_count,  16'd0);
    check("rst_misses", miss_count, 16'd0);
    @(negedge clk); reset_n = 1'b1;

    // 1: cold read miss.
    do_req(1, 0, 16'h0025, 16'h0, 0, lat, rdata, rdc, wrc, maddr, mdata);
    check("t1_lat",   lat,        6);
    check("t1_rdata", rdata,      16'h6100);
    check("t1_rdcyc", rdc,        1);
    check("t1_maddr", maddr,      16'h0024);
    check("t1_miss",  miss_count, 16'd1);

    // 2: read hit in the same line.
    do_req(1, 0, 16'h0027, 16'h0, 0, lat, rdata, rdc, wrc, maddr, mdata);
    check("t2_lat",   lat,       0);
    check("t2_rdata", rdata,     16'h6200);
    check("t2_hit",   hit_count, 16'd1);
    check("t2_rdcyc", rdc,       0);

    // 3: write hit, full-line write-through, then read back.
    do_req(0, 1, 16'h0026, 16'hBEEF, 0, lat, rdata, rdc, wrc, maddr, mdata);
    check("t3_lat",   lat,   6);
    check("t3_wrcyc", wrc,   1);
    check("t3_maddr", maddr, 16'h0024);
    check("t3_mdata", mdata, 64'h6200_BEEF_6100_F01C);
    check("t3_mem",   mem[10'h026], 16'hBEEF);
    do_req(1, 0, 16'h0026, 16'h0, 0, lat, rdata, rdc, wrc, maddr, mdata);
    check("t3_rb_lat",   lat,   0);
    check("t3_rb_rdata", rdata, 16'hBEEF);

    // 4: conflict miss evicts, refetch proves write-through.
    do_req(1, 0, 16'h0034, 16'h0, 0, lat, rdata, rdc, wrc, maddr, mdata);
    check("t4_lat",   lat,   6);
    check("t4_rdata", rdata, 16'hF41C);
    do_req(1, 0, 16'h0026, 16'h0, 0, lat, rdata, rdc, wrc, maddr, mdata);
    check("t4_re_lat",   lat,        6);
    check("t4_re_rdata", rdata,      16'hBEEF);
    check("t4_miss",     miss_count, 16'd3);
    check("t4_hit",      hit_count,  16'd3);

    // 5: cold write miss: fill then write-back.
    do_req(0, 1, 16'h01F5, 16'h1234, 0, lat, rdata, rdc, wrc, maddr, mdata);
    check("t5_lat",   lat,   12);
    check("t5_mdata", mdata, 64'h0000_0000_1234_0000);
    check("t5_mem0",  mem[10'h1F4], 16'h0000);
    check("t5_mem1",  mem[10'h1F5], 16'h1234);
    check("t5_mem2",  mem[10'h1F6], 16'h0000);
    check("t5_mem3",  mem[10'h1F7], 16'h0000);
    check("t5_miss",  miss_count,   16'd4);

    // Memory busy for two REQ edges adds two edges of latency.
    do_req(1, 0, 16'h0022, 16'h0, 2, lat, rdata, rdc, wrc, maddr, mdata);
    check("st_lat",   lat,   8);
    check("st_rdcyc", rdc,   3);
    check("st_rdata", rdata, 16'h5A5A);

    // Read and write both high: treated as a write (hit).
    do_req(1, 1, 16'h0022, 16'h0F0F, 0, lat, rdata, rdc, wrc, maddr, mdata);
    check("both_lat",   lat,          6);
    check("both_wrcyc", wrc,          1);
    check("both_mem",   mem[10'h022], 16'h0F0F);
    check("both_hit",   hit_count,    16'd4);

    // 6: reset asserted during FILL_WAIT.
    @(negedge clk);
    c_readC = 1'b1; c_address = 16'h0027;
    repeat (3) @(posedge clk);
    #1;
    check("t6_in_fill", dut.state_q == dut.FILL_WAIT, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t6_readM", m_readM,    1'b0);
    check("t6_done",  c_doneC,    1'b0);
    check("t6_hits",  hit_count,  16'd0);
    check("t6_miss",  miss_count, 16'd0);
    c_readC = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    do_req(1, 0, 16'h0027, 16'h0, 0, lat, rdata, rdc, wrc, maddr, mdata);
    check("t6_lat",   lat,        6);
    check("t6_rdata", rdata,      16'h6200);
    check("t6_miss1", miss_count, 16'd1);
    check("t6_hit0",  hit_count,  16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
